// File: rtl/alu_seq.sv
// Multi-cycle execute-stage ALU: logic/add/compare ops finish in one cycle and shifts
// iterate one bit per cycle. Requests and results use valid/ready handshakes.
module alu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);
    localparam int SW = $clog2(XLEN);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLTU = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic            zero;
        logic            illegal;
    } resp_t;

    state_e          state, state_d;
    logic [XLEN-1:0] acc, acc_d;
    logic [SW-1:0]   cnt, cnt_d;
    logic [1:0]      kind, kind_d;
    resp_t           resp_q, resp_d;

    logic            is_shift;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] step;

    // kind: 00 SLL, 01 SRL, 10 SRA (low bits of the shift opcodes)
    function automatic logic [XLEN-1:0] shift1(input logic [1:0] k, input logic [XLEN-1:0] v);
        case (k)
            2'b00:   return {v[XLEN-2:0], 1'b0};
            2'b01:   return {1'b0, v[XLEN-1:1]};
            default: return {v[XLEN-1], v[XLEN-1:1]};
        endcase
    endfunction

    function automatic resp_t mk_resp(input logic [XLEN-1:0] v);
        resp_t r;
        r.result  = v;
        r.zero    = (v == '0);
        r.illegal = 1'b0;
        return r;
    endfunction

    // Illegal codes leave v at zero, so zero=1 and illegal=1 fall out together.
    function automatic resp_t exec_single(input logic [3:0] op, input logic [XLEN-1:0] x,
                                          input logic [XLEN-1:0] y);
        resp_t           r;
        logic [XLEN-1:0] v;
        logic            legal;
        v     = '0;
        legal = 1'b1;
        case (op)
            OP_AND:  v = x & y;
            OP_OR:   v = x | y;
            OP_ADD:  v = x + y;
            OP_XOR:  v = x ^ y;
            OP_SLTU: v = {{(XLEN-1){1'b0}}, (x < y)};
            OP_SUB:  v = x - y;
            OP_SLT:  v = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
            default: legal = 1'b0;
        endcase
        r.result  = v;
        r.zero    = (v == '0);
        r.illegal = !legal;
        return r;
    endfunction

    assign is_shift = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);
    assign shamt    = b[SW-1:0];

    // One shifter serves both the first step (taken at acceptance) and the SHIFT steps,
    // which makes shift latency equal to shamt.
    assign step = shift1((state == IDLE) ? alu_op[1:0] : kind, (state == IDLE) ? a : acc);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = resp_q.result;
    assign zero      = resp_q.zero;
    assign illegal   = resp_q.illegal;

    always_comb begin
        state_d = state;
        acc_d   = acc;
        cnt_d   = cnt;
        kind_d  = kind;
        resp_d  = resp_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (is_shift) begin
                        kind_d = alu_op[1:0];
                        if (shamt == '0) begin
                            resp_d  = mk_resp(a);
                            state_d = DONE;
                        end else if (shamt == SW'(1)) begin
                            resp_d  = mk_resp(step);
                            state_d = DONE;
                        end else begin
                            acc_d   = step;
                            cnt_d   = shamt - SW'(1);
                            state_d = SHIFT;
                        end
                    end else begin
                        resp_d  = exec_single(alu_op, a, b);
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                acc_d = step;
                cnt_d = cnt - SW'(1);
                if (cnt == SW'(1)) begin
                    resp_d  = mk_resp(step);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            kind   <= '0;
            resp_q <= '0;
        end else begin
            state  <= state_d;
            acc    <= acc_d;
            cnt    <= cnt_d;
            kind   <= kind_d;
            resp_q <= resp_d;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes model results, a negedge monitor pops
// and compares result/zero/illegal/latency and handshake behaviour.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero, illegal;

    alu_seq #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        ill;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   stall_left = 0;
    logic prev_vld = 1'b0;
    logic idle_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: whole-word arithmetic straight from the opcode table.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        int   sh;
        sh    = int'(y[4:0]);
        e.res = 32'h0;
        e.ill = 1'b0;
        e.lat = 1;
        e.acc_cyc = 0;
        case (op)
            4'h0: e.res = x & y;
            4'h1: e.res = x | y;
            4'h2: e.res = x + y;
            4'h3: e.res = x ^ y;
            4'h4: e.res = (x < y) ? 32'd1 : 32'd0;
            4'h6: e.res = x - y;
            4'h7: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'h8: e.res = x << sh;
            4'h9: e.res = x >> sh;
            4'hA: e.res = 32'($signed(x) >>> sh);
            default: e.ill = 1'b1;
        endcase
        if (op >= 4'h8 && op <= 4'hA && sh > 0) e.lat = sh;
        e.z = (e.res == 32'h0);
        return e;
    endfunction

    // Monitor: decides out_ready for the coming edge and scores whatever the DUT shows.
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {32'h0, result}, 64'hDEAD_BEEF);
            end else begin
                if (!prev_vld) check("latency", 64'(cyc - sb[0].acc_cyc + 1), 64'(sb[0].lat));
                check("result", {32'h0, result}, {32'h0, sb[0].res});
                check("zero", {63'h0, zero}, {63'h0, sb[0].z});
                check("illegal", {63'h0, illegal}, {63'h0, sb[0].ill});
            end
            check("in_ready_in_done", {63'h0, in_ready}, 64'h0);
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = ($urandom_range(3) != 0);
            end
            if (out_ready) begin
                if (sb.size() > 0) void'(sb.pop_front());
                idle_chk = 1'b1;
            end
        end else begin
            if (idle_chk) check("in_ready_after_handshake", {63'h0, in_ready}, 64'h1);
            idle_chk  = 1'b0;
            out_ready = $urandom_range(1);
        end
        prev_vld = out_valid;
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'h0, 64'h1);
            return;
        end
        in_valid  = 1'b1;
        alu_op    = op;
        a         = x;
        b         = y;
        e         = model(op, x, y);
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        // Scramble operands after acceptance; the DUT must ignore them.
        in_valid = 1'b0;
        alu_op   = 4'($urandom);
        a        = $urandom;
        b        = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(sb.size()), 64'h0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        alu_op   = 4'h0;
        a        = 32'h0;
        b        = 32'h0;
        #1;
        check("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_result", {32'h0, result}, 64'h0);
        check("rst_zero", {63'h0, zero}, 64'h0);
        check("rst_illegal", {63'h0, illegal}, 64'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {63'h0, in_ready}, 64'h1);

        issue(4'h2, 32'd5, 32'd7);
        issue(4'h6, 32'd3, 32'd3);
        issue(4'h7, 32'hFFFF_FFFF, 32'd1);
        issue(4'h4, 32'hFFFF_FFFF, 32'd1);
        issue(4'h8, 32'd1, 32'd4);
        issue(4'hA, 32'h8000_0000, 32'd31);
        issue(4'h9, 32'h8000_0000, 32'd31);
        issue(4'h8, 32'h1234_5678, 32'h20);
        issue(4'h9, 32'hF000_000F, 32'd1);
        issue(4'hF, 32'h1111_1111, 32'h2222_2222);
        issue(4'h0, 32'hF0F0_FFFF, 32'h0FF0_F00F);
        drain();

        // Backpressure: result held, no acceptance while DONE.
        stall_left = 5;
        issue(4'h3, 32'hA5A5_0000, 32'h0000_5A5A);
        begin
            int n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("stall_reach_done", {63'h0, out_valid}, 64'h1);
        end
        in_valid = 1'b1;
        alu_op   = 4'h2;
        a        = 32'd9;
        b        = 32'd9;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", {63'h0, in_ready}, 64'h0);
        end
        in_valid = 1'b0;
        drain();

        // Reset in the middle of a long shift discards it.
        issue(4'h8, $urandom | 32'h1, 32'd20);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {63'h0, out_valid}, 64'h0);
        check("midrst_result", {32'h0, result}, 64'h0);
        sb.delete();
        stall_left = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", {63'h0, in_ready}, 64'h1);
        issue(4'h2, 32'd1, 32'd1);
        drain();

        for (int i = 0; i < 200; i++) begin
            logic [3:0]  op;
            logic [31:0] x, y;
            op = 4'($urandom);
            x  = $urandom;
            y  = $urandom;
            case ($urandom_range(3))
                0: y = y & 32'h0000_0003;
                1: x = y;
                2: x = x | 32'h8000_0000;
                default: ;
            endcase
            if ($urandom_range(7) == 0) stall_left = int'($urandom_range(6));
            issue(op, x, y);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
